// File: rtl/rst_seq_ctrl_if.sv
// Interface for the reset sequencing controller. It bundles the synchronizer input, the
// software request, the gap setting, the per-domain acknowledges, the domain resets and the status.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 8
);
  logic               SYNC_RST;
  logic               SW_RST_REQ;
  logic [CNT_W-1:0]   HOLD_CFG;
  logic [NUM_DOM-1:0] DOM_ACK;
  logic [NUM_DOM-1:0] DOM_RST_N;
  logic               SEQ_BUSY;
  logic               SEQ_DONE;
  logic               TIMEOUT_ERR;
  logic [NUM_DOM-1:0] ERR_DOM;

  modport master (
    output SYNC_RST, SW_RST_REQ, HOLD_CFG, DOM_ACK,
    input  DOM_RST_N, SEQ_BUSY, SEQ_DONE, TIMEOUT_ERR, ERR_DOM
  );

  modport slave (
    input  SYNC_RST, SW_RST_REQ, HOLD_CFG, DOM_ACK,
    output DOM_RST_N, SEQ_BUSY, SEQ_DONE, TIMEOUT_ERR, ERR_DOM
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller. It holds every domain in reset and then releases the domains
// in index order. Before each release it waits a programmable gap, and after it waits for that domain's acknowledge.
module rst_seq_ctrl #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 8,
  parameter int ACK_TO  = 255
) (
  input logic         CLK,
  input logic         RST,
  rst_seq_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);
  localparam logic [15:0]      TO_LAST  = 16'(ACK_TO - 1);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_HOLD,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [15:0]        to_q, to_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic [NUM_DOM-1:0] err_dom_q, err_dom_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               resync;
  logic [CNT_W-1:0]   hold_val;

  assign resync   = !bus.SYNC_RST || bus.SW_RST_REQ;
  assign hold_val = (bus.HOLD_CFG == '0) ? CNT_W'(1) : bus.HOLD_CFG;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    to_d      = to_q;
    dom_d     = dom_q;
    err_dom_d = err_dom_q;

    case (state_q)
      S_ASSERT: begin
        dom_d     = '0;
        err_dom_d = '0;
        idx_d     = '0;
        if (!resync) begin
          state_d = S_HOLD;
          gap_d   = hold_val;
        end
      end

      S_HOLD: begin
        if (resync) begin
          state_d = S_ASSERT;
        end else if (gap_q <= CNT_W'(1)) begin
          dom_d[idx_q] = 1'b1;
          to_d         = '0;
          state_d      = S_WAIT_ACK;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      // An acknowledge that arrives on the same edge as the timeout takes priority.
      S_WAIT_ACK: begin
        if (resync) begin
          state_d = S_ASSERT;
        end else if (bus.DOM_ACK[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            gap_d   = hold_val;
            state_d = S_HOLD;
          end
        end else if (to_q == TO_LAST) begin
          err_dom_d[idx_q] = 1'b1;
          state_d          = S_ERR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        if (resync) state_d = S_ASSERT;
      end

      default: state_d = S_ASSERT;
    endcase

    // Leaving for ASSERT drops every domain on the same edge.
    if (state_d == S_ASSERT) begin
      dom_d     = '0;
      err_dom_d = '0;
      idx_d     = '0;
    end

    busy_d = (state_d == S_HOLD) || (state_d == S_WAIT_ACK);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_ASSERT;
      idx_q     <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      dom_q     <= '0;
      err_dom_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      dom_q     <= dom_d;
      err_dom_q <= err_dom_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.DOM_RST_N   = dom_q;
  assign bus.SEQ_BUSY    = busy_q;
  assign bus.SEQ_DONE    = done_q;
  assign bus.TIMEOUT_ERR = err_q;
  assign bus.ERR_DOM     = err_dom_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl. Each step pushes the outputs it expects after the next edge
// onto a scoreboard, and the entry is popped and compared one time unit after that edge.
module tb_rst_seq_ctrl;
  localparam int N      = 4;
  localparam int CNT_W  = 8;
  localparam int ACK_TO = 8;

  typedef struct {
    logic [N-1:0] dom;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] errDom;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  rst_seq_ctrl_if #(.NUM_DOM(N), .CNT_W(CNT_W)) bus ();

  rst_seq_ctrl #(.NUM_DOM(N), .CNT_W(CNT_W), .ACK_TO(ACK_TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic [N-1:0] dom, input logic busy, input logic done,
                               input logic err, input logic [N-1:0] errDom);
    exp_t e;
    e.dom    = dom;
    e.busy   = busy;
    e.done   = done;
    e.err    = err;
    e.errDom = errDom;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    logic [N+2:0] obsStat, expStat;
    @(posedge CLK);
    #1;
    e = scoreboard.pop_front();
    expStat = {e.busy, e.done, e.err, e.errDom};
    obsStat = {bus.SEQ_BUSY, bus.SEQ_DONE, bus.TIMEOUT_ERR, bus.ERR_DOM};
    checks++;
    assert (bus.DOM_RST_N === e.dom) else begin
      errors++;
      $error("[TB] FAIL %s dom_rst_n observed=%b expected=%b", tag, bus.DOM_RST_N, e.dom);
    end
    checks++;
    assert (obsStat === expStat) else begin
      errors++;
      $error("[TB] FAIL %s busy/done/err/err_dom observed=%b expected=%b", tag, obsStat, expStat);
    end
  endtask

  task automatic step(input string tag, input logic [N-1:0] dom, input logic busy,
                      input logic done, input logic err, input logic [N-1:0] errDom);
    applyStimulus(dom, busy, done, err, errDom);
    checkOutput(tag);
  endtask

  task automatic swPulse();
    bus.SW_RST_REQ = 1'b1;
    step("sw_reset", '0, 1'b0, 1'b0, 1'b0, '0);
    bus.SW_RST_REQ = 1'b0;
  endtask

  // Domain i is released on edge (i+1)*(g+1), where edge 1 enters HOLD.
  task automatic runNominal(input int h, input string tag);
    int g, per, cnt;
    logic [N-1:0] d;
    bus.HOLD_CFG = CNT_W'(h);
    bus.DOM_ACK  = '1;
    g   = (h == 0) ? 1 : h;
    per = g + 1;
    for (int k = 1; k <= N * per + 2; k++) begin
      cnt = k / per;
      if (cnt > N) cnt = N;
      d = '0;
      for (int i = 0; i < cnt; i++) d[i] = 1'b1;
      step(tag, d, (k <= N * per), (k > N * per), 1'b0, '0);
    end
  endtask

  initial begin
    RST            = 1'b1;
    bus.SYNC_RST   = 1'b1;
    bus.SW_RST_REQ = 1'b0;
    bus.HOLD_CFG   = CNT_W'(3);
    bus.DOM_ACK    = '1;

    $display("[TB] reset state");
    step("reset", '0, 1'b0, 1'b0, 1'b0, '0);
    step("reset", '0, 1'b0, 1'b0, 1'b0, '0);
    RST = 1'b0;

    $display("[TB] nominal HOLD_CFG=3");
    runNominal(3, "nominal_h3");

    $display("[TB] RST in DONE");
    RST = 1'b1;
    step("rst_in_done", '0, 1'b0, 1'b0, 1'b0, '0);
    RST = 1'b0;
    runNominal(3, "after_rst");

    $display("[TB] HOLD_CFG=0");
    swPulse();
    runNominal(0, "hold_zero");

    $display("[TB] timeout on domain 1");
    swPulse();
    bus.HOLD_CFG = CNT_W'(2);
    bus.DOM_ACK  = 4'b1101;
    for (int k = 1; k <= 17; k++) begin
      step("timeout",
           (k >= 6) ? 4'b0011 : ((k >= 3) ? 4'b0001 : 4'b0000),
           (k <= 13), 1'b0, (k >= 14), (k >= 14) ? 4'b0010 : 4'b0000);
    end
    swPulse();
    runNominal(2, "restart_after_err");

    $display("[TB] late acknowledge");
    swPulse();
    bus.HOLD_CFG = CNT_W'(1);
    bus.DOM_ACK  = 4'b1110;
    step("late_ack", 4'b0000, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 2; k <= 9; k++) step("late_ack", 4'b0001, 1'b1, 1'b0, 1'b0, '0);
    bus.DOM_ACK = 4'b1111;
    step("late_ack_edge", 4'b0001, 1'b1, 1'b0, 1'b0, '0);
    step("late_ack", 4'b0011, 1'b1, 1'b0, 1'b0, '0);
    step("late_ack", 4'b0011, 1'b1, 1'b0, 1'b0, '0);
    step("late_ack", 4'b0111, 1'b1, 1'b0, 1'b0, '0);
    step("late_ack", 4'b0111, 1'b1, 1'b0, 1'b0, '0);
    step("late_ack", 4'b1111, 1'b1, 1'b0, 1'b0, '0);
    step("late_ack", 4'b1111, 1'b0, 1'b1, 1'b0, '0);
    step("late_ack", 4'b1111, 1'b0, 1'b1, 1'b0, '0);

    $display("[TB] abort in WAIT_ACK of domain 2");
    swPulse();
    bus.HOLD_CFG = CNT_W'(1);
    bus.DOM_ACK  = 4'b1011;
    step("abort_pre", 4'b0000, 1'b1, 1'b0, 1'b0, '0);
    step("abort_pre", 4'b0001, 1'b1, 1'b0, 1'b0, '0);
    step("abort_pre", 4'b0001, 1'b1, 1'b0, 1'b0, '0);
    step("abort_pre", 4'b0011, 1'b1, 1'b0, 1'b0, '0);
    step("abort_pre", 4'b0011, 1'b1, 1'b0, 1'b0, '0);
    step("abort_pre", 4'b0111, 1'b1, 1'b0, 1'b0, '0);
    bus.SYNC_RST = 1'b0;
    step("abort", 4'b0000, 1'b0, 1'b0, 1'b0, '0);
    step("abort", 4'b0000, 1'b0, 1'b0, 1'b0, '0);
    bus.SYNC_RST = 1'b1;
    runNominal(3, "abort_restart");

    checks++;
    assert (scoreboard.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=0", scoreboard.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencing controller that sits downstream of the reset synchronizer, in the same CLK domain. It holds NUM_DOM reset domains in reset while the synchronized reset is active or software requests a reset. It then releases the domains one at a time, in index order 0 to NUM_DOM-1, waiting a programmable gap before each release and waiting for each domain's ready acknowledge before moving to the next. A domain that fails to acknowledge in time stops the sequence and is reported as an error.

Parameters:
NUM_DOM, 4, number of sequenced reset domains (2..8)
CNT_W, 8, width of the gap counter and HOLD_CFG
ACK_TO, 255, cycles allowed in WAIT_ACK before timeout (1..2^16-1)

Ports:
CLK  in  1  single system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
SYNC_RST  in  1  active-low synchronized reset from the upstream synchronizer, already in CLK domain; 0 = domains must be in reset
SW_RST_REQ  in  1  software re-sequence request, level or pulse
HOLD_CFG  in  CNT_W  gap in cycles before each release; 0 treated as 1
DOM_ACK  in  NUM_DOM  per-domain ready indication
DOM_RST_N  out  NUM_DOM  active-low domain resets; bit i drives domain i
SEQ_BUSY  out  1  1 in HOLD and WAIT_ACK
SEQ_DONE  out  1  1 in DONE only
TIMEOUT_ERR  out  1  1 in ERR only
ERR_DOM  out  NUM_DOM  one-hot index of the domain that timed out; 0 otherwise

Behaviour:
- All outputs are registered. On any edge with RST=1 the block enters ASSERT and sets: DOM_RST_N=0, SEQ_BUSY=0, SEQ_DONE=0, TIMEOUT_ERR=0, ERR_DOM=0, idx=0, gap counter=0, timeout counter=0.
- States: ASSERT, HOLD, WAIT_ACK, DONE, ERR.
- ASSERT:
  - DOM_RST_N=0.
  - Leave for HOLD on the first edge with SYNC_RST=1 and SW_RST_REQ=0.
  - On that edge: load gap counter with max(HOLD_CFG,1) and set idx=0. HOLD_CFG is sampled only on this edge and on the WAIT_ACK->HOLD edge.
- HOLD:
  - Gap counter decrements each edge.
  - On the edge where the counter is 1: set DOM_RST_N[idx]=1, clear the timeout counter, go to WAIT_ACK.
  - Domain idx is therefore released exactly max(HOLD_CFG,1) edges after HOLD entry.
- WAIT_ACK:
  - DOM_ACK[idx] sampled 1:
    - if idx=NUM_DOM-1, go to DONE;
    - otherwise idx+1, reload the gap counter, go to HOLD.
  - Otherwise the timeout counter increments. When it reaches ACK_TO, go to ERR, set TIMEOUT_ERR=1 and ERR_DOM[idx]=1.
  - Acknowledge and timeout on the same edge: acknowledge wins.
- DONE: all DOM_RST_N=1; stays until a re-sequence.
- ERR: domains released so far stay released; the rest stay in reset; stays until a re-sequence or RST.
- Re-sequence: SYNC_RST=0 or SW_RST_REQ=1 sampled in any state except ASSERT.
  - Next edge: DOM_RST_N=0 (all together, same edge), enter ASSERT, clear SEQ_DONE, TIMEOUT_ERR, ERR_DOM, idx.
  - Mid-sequence requests abort immediately.
  - Priority: RST > re-sequence > acknowledge > timeout > count.
- DOM_ACK bits other than idx are ignored. DOM_ACK dropping after a domain's release is not monitored.
- Released-domain bits never deassert out of order; DOM_RST_N is always thermometer-coded from bit 0.

Test Plan:
- Nominal, NUM_DOM=4, HOLD_CFG=3, DOM_ACK=4'b1111, SYNC_RST=1; E1 = first edge with RST=0 → HOLD at E1. DOM_RST_N bit0 rises at E4, bit1 at E8, bit2 at E12, bit3 at E16. SEQ_DONE=1 at E17. SEQ_BUSY=1 from E1 through E16.
- HOLD_CFG=0 → identical to HOLD_CFG=1: bit0 at E2, bit1 at E4, bit2 at E6, bit3 at E8, SEQ_DONE at E9.
- Timeout, ACK_TO=8, DOM_ACK=4'b1101, HOLD_CFG=2 → DOM_RST_N=4'b0011 held. TIMEOUT_ERR=1 and ERR_DOM=4'b0010 exactly 8 edges after bit1 release. SEQ_BUSY=0. A SW_RST_REQ pulse then clears the error and restarts the sequence.
- Abort mid-sequence: SYNC_RST driven 0 for 2 cycles while in WAIT_ACK for domain 2 (DOM_RST_N=4'b0111) → DOM_RST_N=4'b0000 on the next edge. Sequence restarts from domain 0 once SYNC_RST=1, with HOLD_CFG resampled.
- Late acknowledge: DOM_ACK[0] asserted on the same edge the timeout counter reaches ACK_TO → no error; sequence proceeds to domain 1.
- RST asserted in DONE → next edge: all outputs at reset values, DOM_RST_N=0. After RST release the full sequence repeats with identical timing.
